// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, flag bit indices,
// the per-opcode flag write mask and the skid FIFO fill states.
package alu_pkg;

  localparam int DATA_W     = 8;
  localparam int FLAG_BITS  = 4;
  localparam int REG_ADDR_W = 3;

  localparam logic [3:0] ADD_OP = 4'b0000;
  localparam logic [3:0] SUB_OP = 4'b0001;
  localparam logic [3:0] AND_OP = 4'b0010;
  localparam logic [3:0] OR_OP  = 4'b0011;
  localparam logic [3:0] XOR_OP = 4'b0100;

  localparam int ZERO_FLAG  = 0;
  localparam int CARRY_FLAG = 1;
  localparam int NEG_FLAG   = 2;
  localparam int OVER_FLAG  = 3;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} fill_state_e;

  // Which status bits an opcode may write; all-zero marks an illegal opcode.
  function automatic logic [FLAG_BITS-1:0] flag_mask(input logic [3:0] func_op);
    logic [FLAG_BITS-1:0] m;
    m = '0;
    case (func_op)
      ADD_OP, SUB_OP: m = '1;
      AND_OP, OR_OP, XOR_OP: begin
        m[ZERO_FLAG] = 1'b1;
        m[NEG_FLAG]  = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU/writeback side (master) and the result stage (slave).
interface alu_result_stage_if #(
  parameter int DataWidth    = 8,
  parameter int FlagBits     = 4,
  parameter int RegAddrWidth = 3
);
  logic                    InValid;
  logic                    InReady;
  logic [DataWidth-1:0]    Y;
  logic [FlagBits-1:0]     OFlags;
  logic [3:0]              FuncOp;
  logic [RegAddrWidth-1:0] InDest;
  logic                    FlagLoad;
  logic [FlagBits-1:0]     FlagLoadData;
  logic [FlagBits-1:0]     Flags;
  logic                    OutValid;
  logic                    OutReady;
  logic [DataWidth-1:0]    OutData;
  logic [RegAddrWidth-1:0] OutDest;
  logic                    OpErr;

  modport master (
    output InValid, Y, OFlags, FuncOp, InDest, FlagLoad, FlagLoadData, OutReady,
    input  InReady, Flags, OutValid, OutData, OutDest, OpErr
  );

  modport slave (
    input  InValid, Y, OFlags, FuncOp, InDest, FlagLoad, FlagLoadData, OutReady,
    output InReady, Flags, OutValid, OutData, OutDest, OpErr
  );
endinterface

// File: rtl/result_fifo2.sv
// Two-entry skid FIFO carrying {dest, data}. Head is always presented on
// out_data; the tail slot only fills while the head is stalled.
module result_fifo2
  import alu_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  fill_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign pop       = out_valid & out_ready;

  // Fill-state transitions; a push+pop in ONE replaces the head in place.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = push_data;
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          state_d = TWO;
          tail_d  = push_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: if (pop) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the 8-bit ALU: buffers results for writeback in a
// 2-entry skid FIFO and owns the V,N,C,Z status register fed back to the ALU.
// Optional combinational bypass when empty: ALU_RESULT_BYPASS_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DataWidth    = DATA_W,
  parameter int FlagBits     = FLAG_BITS,
  parameter int RegAddrWidth = REG_ADDR_W
) (
  input logic               Clk,
  input logic               Reset_N,
  alu_result_stage_if.slave bus
);

  localparam int EntW = DataWidth + RegAddrWidth;

  logic [FlagBits-1:0] flags_q, flags_d;
  logic                op_err_q, op_err_d;
  logic [FlagBits-1:0] mask;
  logic                accept, legal, bypass, push;
  logic                fifo_ready, fifo_valid;
  logic [EntW-1:0]     fifo_head;

  assign mask   = flag_mask(bus.FuncOp);
  assign legal  = |mask;
  assign accept = bus.InValid & fifo_ready;

`ifdef ALU_RESULT_BYPASS_EN
  assign bypass = !fifo_valid & bus.InValid & legal & bus.OutReady;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & legal & !bypass;

  result_fifo2 #(.W(EntW)) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_N),
    .push      (push),
    .push_data ({bus.InDest, bus.Y}),
    .in_ready  (fifo_ready),
    .out_valid (fifo_valid),
    .out_ready (bus.OutReady),
    .out_data  (fifo_head)
  );

  assign bus.InReady  = fifo_ready;
  assign bus.OutValid = fifo_valid | bypass;
  assign bus.OutData  = bypass ? bus.Y      : fifo_head[DataWidth-1:0];
  assign bus.OutDest  = bypass ? bus.InDest : fifo_head[EntW-1:DataWidth];
  assign bus.Flags    = flags_q;
  assign bus.OpErr    = op_err_q;

  // Flags update at accept through the opcode mask; an explicit load wins.
  always_comb begin
    flags_d  = flags_q;
    op_err_d = accept & !legal;
    if (accept && legal)
      flags_d = (flags_q & ~mask) | (bus.OFlags & mask);
    if (bus.FlagLoad)
      flags_d = bus.FlagLoadData;
  end

  // Status register and error pulse.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      flags_q  <= '0;
      op_err_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      op_err_q <= op_err_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; bypass checks follow ALU_RESULT_BYPASS_EN.
module tb_alu_result_stage;

  logic Clk = 1'b0;
  logic Reset_N;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  alu_result_stage_if #(.DataWidth(8), .FlagBits(4), .RegAddrWidth(3)) bus ();

  alu_result_stage #(.DataWidth(8), .FlagBits(4), .RegAddrWidth(3)) dut (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] y,
                       input logic [3:0] of, input logic [2:0] dst);
    bus.InValid = v;
    bus.FuncOp  = op;
    bus.Y       = y;
    bus.OFlags  = of;
    bus.InDest  = dst;
  endtask

  initial begin
    Reset_N          = 1'b0;
    bus.FlagLoad     = 1'b0;
    bus.FlagLoadData = 4'h0;
    bus.OutReady     = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    tick(); tick();
    Reset_N = 1'b1;

    // Preset flags, then reset must clear them even with FlagLoad held
    bus.FlagLoad = 1'b1; bus.FlagLoadData = 4'b1010;
    tick();
    chk("preset_flags", bus.Flags, 4'b1010);
    Reset_N = 1'b0;
    tick();
    Reset_N = 1'b1; bus.FlagLoad = 1'b0;
    chk("rst_flags", bus.Flags, 4'b0000);
    chk("rst_outvalid", bus.OutValid, 1'b0);
    chk("rst_inready", bus.InReady, 1'b1);
    chk("rst_operr", bus.OpErr, 1'b0);

    // Add with zero result, writeback ready
    bus.OutReady = 1'b1;
    drive(1'b1, 4'b0000, 8'h00, 4'b0011, 3'd5);
`ifdef ALU_RESULT_BYPASS_EN
    #1;
    chk("add_byp_valid", bus.OutValid, 1'b1);
    chk("add_byp_dest", bus.OutDest, 3'd5);
    tick();
`else
    tick();
    chk("add_valid", bus.OutValid, 1'b1);
    chk("add_data", bus.OutData, 8'h00);
    chk("add_dest", bus.OutDest, 3'd5);
`endif
    chk("add_flags", bus.Flags, 4'b0011);
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    tick();
    chk("add_drained", bus.OutValid, 1'b0);

    // Logical op keeps C,V
    bus.FlagLoad = 1'b1; bus.FlagLoadData = 4'b1010;
    tick();
    bus.FlagLoad = 1'b0; bus.OutReady = 1'b0;
    drive(1'b1, 4'b0010, 8'h80, 4'b0100, 3'd1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("and_flags", bus.Flags, 4'b1110);
    chk("and_data", bus.OutData, 8'h80);
    bus.OutReady = 1'b1;
    tick();
    chk("and_drained", bus.OutValid, 1'b0);

    // Fill both entries with writeback stalled
    bus.OutReady = 1'b0;
    drive(1'b1, 4'b0000, 8'h11, 4'b0000, 3'd2);
    tick();
    chk("fill1_inready", bus.InReady, 1'b1);
    drive(1'b1, 4'b0000, 8'h22, 4'b0000, 3'd3);
    tick();
    chk("fill2_inready", bus.InReady, 1'b0);
    chk("fill2_head", bus.OutData, 8'h11);
    drive(1'b1, 4'b0000, 8'h33, 4'b0000, 3'd6);
    tick();
    chk("held_inready", bus.InReady, 1'b0);
    chk("held_head", bus.OutData, 8'h11);
    chk("held_dest", bus.OutDest, 3'd2);
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    bus.OutReady = 1'b1;
    tick();
    chk("deq1_data", bus.OutData, 8'h22);
    chk("deq1_dest", bus.OutDest, 3'd3);
    chk("deq1_inready", bus.InReady, 1'b1);
    tick();
    chk("deq2_empty", bus.OutValid, 1'b0);

    // Illegal opcode: error pulse only
    bus.FlagLoad = 1'b1; bus.FlagLoadData = 4'b0110;
    tick();
    bus.FlagLoad = 1'b0;
    drive(1'b1, 4'b0111, 8'hEE, 4'b1001, 3'd4);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("ill_operr", bus.OpErr, 1'b1);
    chk("ill_outvalid", bus.OutValid, 1'b0);
    chk("ill_flags", bus.Flags, 4'b0110);
    chk("ill_inready", bus.InReady, 1'b1);
    tick();
    chk("ill_operr_clr", bus.OpErr, 1'b0);

    // FlagLoad beats the Sub flag update; result still enqueued
    bus.OutReady = 1'b0;
    bus.FlagLoad = 1'b1; bus.FlagLoadData = 4'b0001;
    drive(1'b1, 4'b0001, 8'h5A, 4'b1110, 3'd7);
    tick();
    bus.FlagLoad = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("ld_flags", bus.Flags, 4'b0001);
    chk("ld_valid", bus.OutValid, 1'b1);
    chk("ld_data", bus.OutData, 8'h5A);
    chk("ld_dest", bus.OutDest, 3'd7);

    // Push and pop together in ONE: head replaced
    bus.OutReady = 1'b1;
    drive(1'b1, 4'b0011, 8'h55, 4'b0000, 3'd1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("swap_valid", bus.OutValid, 1'b1);
    chk("swap_data", bus.OutData, 8'h55);
    tick();
    chk("swap_drained", bus.OutValid, 1'b0);

    // Empty, writeback ready: bypass or one-cycle latency
    drive(1'b1, 4'b0100, 8'hC3, 4'b0000, 3'd4);
    #1;
`ifdef ALU_RESULT_BYPASS_EN
    chk("byp_valid", bus.OutValid, 1'b1);
    chk("byp_data", bus.OutData, 8'hC3);
    chk("byp_dest", bus.OutDest, 3'd4);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("byp_not_enq", bus.OutValid, 1'b0);
`else
    chk("lat_pre_valid", bus.OutValid, 1'b0);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("lat_valid", bus.OutValid, 1'b1);
    chk("lat_data", bus.OutData, 8'hC3);
    tick();
`endif

    // Reset mid-transfer discards buffered entries
    bus.OutReady = 1'b0;
    drive(1'b1, 4'b0000, 8'h01, 4'b0000, 3'd1);
    tick(); tick();
    chk("mid_full", bus.InReady, 1'b0);
    Reset_N = 1'b0;
    tick();
    Reset_N = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0);
    chk("mid_rst_valid", bus.OutValid, 1'b0);
    chk("mid_rst_inready", bus.InReady, 1'b1);
    chk("mid_rst_data", bus.OutData, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
